// File: rtl/sram_access_fsm.sv
// Bus-side sequencer for the off-chip SRAM controller: one request at a time,
// driven through setup/access/hold pin phases with registered SRAM outputs.
module sram_access_fsm #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int N_SRAM         = 2,
    parameter int SETUP_CYC      = 1,
    parameter int ACCESS_CYC     = 2,
    parameter int HOLD_CYC       = 1,
    parameter int INVERT_CE_EN   = 1,
    parameter int INVERT_BYTE_EN = 1,
    parameter int WE_OE_ACT_LOW  = 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req_ren,
    input  logic                req_wen,
    input  logic [ADDR_W-1:0]   req_addr,
    input  logic [1:0]          req_size,
    input  logic [DATA_W-1:0]   req_wdata,
    output logic                req_ready,
    output logic                req_err,
    output logic [DATA_W-1:0]   req_rdata,
    output logic                busy,
    output logic [ADDR_W-1:0]   latched_addr,
    output logic [1:0]          latched_size,
    input  logic [3:0]          dec_byte_en,
    input  logic [3:0]          dec_latched_byte_en,
    input  logic [N_SRAM-1:0]   dec_sram_en,
    output logic [ADDR_W-3:0]   sram_addr,
    output logic [N_SRAM-1:0]   sram_ce,
    output logic [3:0]          sram_be,
    output logic                sram_we,
    output logic                sram_oe,
    output logic [DATA_W-1:0]   sram_wdata,
    output logic                sram_wdata_oe,
    input  logic [DATA_W-1:0]   sram_rdata
);

    typedef enum logic [2:0] {IDLE, SETUP, ACCESS, HOLD, DONE} state_t;

    localparam logic              CE_LOW  = (INVERT_CE_EN != 0);
    localparam logic              BE_LOW  = (INVERT_BYTE_EN != 0);
    localparam logic              STB_OFF = (WE_OE_ACT_LOW != 0);
    localparam logic              STB_ON  = !STB_OFF;
    localparam logic [N_SRAM-1:0] CE_OFF  = {N_SRAM{CE_LOW}};
    localparam logic [3:0]        BE_OFF  = {4{BE_LOW}};
    localparam logic [2:0]        SETUP_LD  = 3'(SETUP_CYC - 1);
    localparam logic [2:0]        ACCESS_LD = 3'(ACCESS_CYC - 1);
    localparam logic [2:0]        HOLD_LD   = 3'(HOLD_CYC - 1);

    state_t              state;
    logic [2:0]          cnt;
    logic                op_wr;
    logic [N_SRAM-1:0]   ce_q;
    logic                misaligned;
    logic [DATA_W-1:0]   rdata_masked;

    always_comb begin
        misaligned = 1'b0;
        case (req_size)
            2'd0:    misaligned = 1'b0;
            2'd1:    misaligned = req_addr[0];
            2'd2:    misaligned = |req_addr[1:0];
            default: misaligned = 1'b1;
        endcase
    end

    always_comb begin
        rdata_masked = '0;
        for (int unsigned i = 0; i < 4; i++) begin
            if (sram_be[i] != BE_LOW) rdata_masked[8*i +: 8] = sram_rdata[8*i +: 8];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            op_wr         <= 1'b0;
            ce_q          <= '0;
            req_ready     <= 1'b0;
            req_err       <= 1'b0;
            req_rdata     <= '0;
            busy          <= 1'b0;
            latched_addr  <= '0;
            latched_size  <= '0;
            sram_addr     <= '0;
            sram_ce       <= CE_OFF;
            sram_be       <= BE_OFF;
            sram_we       <= STB_OFF;
            sram_oe       <= STB_OFF;
            sram_wdata    <= '0;
            sram_wdata_oe <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ren || req_wen) begin
                        latched_addr <= req_addr;
                        latched_size <= req_size;
                        op_wr        <= req_wen;
                        ce_q         <= dec_sram_en;
                        busy         <= 1'b1;
                        if (misaligned) begin
                            state     <= DONE;
                            req_ready <= 1'b1;
                            req_err   <= 1'b1;
                        end else begin
                            // Latched decode is not valid until after this edge, so the first
                            // SETUP cycle takes BE from the unlatched decode of the same address.
                            state         <= SETUP;
                            cnt           <= SETUP_LD;
                            sram_addr     <= req_addr[ADDR_W-1:2];
                            sram_ce       <= dec_sram_en;
                            sram_be       <= dec_byte_en;
                            sram_wdata_oe <= req_wen;
                            if (req_wen) sram_wdata <= req_wdata;
                        end
                    end
                end
                SETUP: begin
                    sram_ce <= ce_q;
                    sram_be <= dec_latched_byte_en;
                    if (cnt == 3'd0) begin
                        state <= ACCESS;
                        cnt   <= ACCESS_LD;
                        if (op_wr) sram_we <= STB_ON;
                        else       sram_oe <= STB_ON;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                ACCESS: begin
                    sram_be <= dec_latched_byte_en;
                    if (cnt == 3'd0) begin
                        state     <= HOLD;
                        cnt       <= HOLD_LD;
                        sram_we   <= STB_OFF;
                        sram_oe   <= STB_OFF;
                        req_rdata <= op_wr ? '0 : rdata_masked;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                HOLD: begin
                    if (cnt == 3'd0) begin
                        state         <= DONE;
                        req_ready     <= 1'b1;
                        req_err       <= 1'b0;
                        sram_ce       <= CE_OFF;
                        sram_be       <= BE_OFF;
                        sram_wdata_oe <= 1'b0;
                    end else begin
                        cnt <= cnt - 3'd1;
                    end
                end
                DONE: begin
                    state     <= IDLE;
                    req_ready <= 1'b0;
                    req_err   <= 1'b0;
                    busy      <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
